// File: rtl/serial_addsub_nbit.sv
// -----------------------------------------------------------------------------
// serial_addsub_nbit
//
// Multi-cycle adder/subtractor for WIDTH-bit operands. Each CALC cycle resolves
// BITS_PER_CYCLE bits, LSB first, through a ripple of full-adder slices. The
// carry between steps is held in a register, so the adder hardware stays small
// and the full result is ready after STEPS = WIDTH/BITS_PER_CYCLE cycles.
//
// Subtraction is done as A + ~B + 1. The incoming carry/borrow is folded into
// the initial carry as (i_cin ^ i_sub), so A - B - borrow becomes
// A + ~B + (1 - borrow). o_carry is therefore a raw carry: 1 means "no borrow".
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_valid      operand request valid
//   o_ready      block can accept operands (IDLE only, and not in reset)
//   i_a, i_b     operands, sampled only at the accept edge
//   i_cin        carry-in when adding, borrow-in when subtracting
//   i_sub        0 = A+B+cin, 1 = A-B-cin
//   o_valid      result valid (DONE state)
//   i_out_ready  downstream accepts the result
//   o_sum        result, modulo 2^WIDTH
//   o_carry      carry out of the MSB
//   o_overflow   two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_addsub_nbit #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Parameter sanity: refuse to elaborate a configuration that cannot
    // assemble a whole result.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_addsub_nbit: WIDTH must be at least 2");
        end
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
            (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
            $error("serial_addsub_nbit: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,     state_next;
    logic [WIDTH-1:0]   a_reg,         a_next;
    logic [WIDTH-1:0]   b_reg,         b_next;      // already inverted for subtract
    logic [WIDTH-1:0]   sum_reg,       sum_next;
    logic               carry_reg,     carry_next;  // carry between steps
    logic [CNT_W-1:0]   count_reg,     count_next;
    logic               carry_out_reg, carry_out_next;
    logic               ovf_reg,       ovf_next;

    // -------------------------------------------------------------------------
    // Ripple of full-adder slices over the low BITS_PER_CYCLE bits.
    // chain[gi] is the carry into slice gi; chain[BITS_PER_CYCLE] leaves the
    // group and becomes the next step's carry.
    // -------------------------------------------------------------------------
    logic [BITS_PER_CYCLE:0]   chain;
    logic [BITS_PER_CYCLE-1:0] slice_sum;

    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_slice
            assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) |
                                   (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // The partial sum enters at the top of the result register and older
    // groups move down, so after STEPS shifts the first (LSB) group sits at
    // bit 0. With one step per operation the slice output is the result.
    logic [WIDTH-1:0] sum_shifted;

    generate
        if (BITS_PER_CYCLE == WIDTH) begin : g_sum_single
            assign sum_shifted = slice_sum;
        end else begin : g_sum_shift
            assign sum_shifted = {slice_sum, sum_reg[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        sum_next       = sum_reg;
        carry_next     = carry_reg;
        count_next     = count_reg;
        carry_out_next = carry_out_reg;
        ovf_next       = ovf_reg;

        case (state_reg)
            IDLE: begin
                // o_ready is high whenever IDLE is not under reset, and reset
                // has priority in the register process, so i_valid suffices.
                if (i_valid) begin
                    a_next     = i_a;
                    b_next     = i_sub ? ~i_b : i_b;
                    carry_next = i_cin ^ i_sub;
                    count_next = '0;
                    state_next = CALC;
                end
            end

            CALC: begin
                a_next     = a_reg >> BITS_PER_CYCLE;
                b_next     = b_reg >> BITS_PER_CYCLE;
                sum_next   = sum_shifted;
                carry_next = chain[BITS_PER_CYCLE];
                count_next = count_reg + CNT_W'(1);
                if (count_reg == LAST_STEP) begin
                    // Final group holds the MSB: overflow is the carry into
                    // the MSB slice differing from the carry out of it.
                    carry_out_next = chain[BITS_PER_CYCLE];
                    ovf_next       = chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
                    count_next     = '0;
                    state_next     = DONE;
                end
            end

            DONE: begin
                if (i_out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            carry_out_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            sum_reg       <= sum_next;
            carry_reg     <= carry_next;
            count_reg     <= count_next;
            carry_out_reg <= carry_out_next;
            ovf_reg       <= ovf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_ready    = (state_reg == IDLE) && !i_rst;
    assign o_valid    = (state_reg == DONE);
    assign o_sum      = sum_reg;
    assign o_carry    = carry_out_reg;
    assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_nbit
//
// Self-checking bench for serial_addsub_nbit. Three instances cover
// WIDTH=8/BPC=1, WIDTH=8/BPC=4 and WIDTH=16/BPC=16. Expected results come from
// a plain integer model, are queued when an operation is accepted, and are
// popped when the selected instance raises o_valid.
// -----------------------------------------------------------------------------
module tb_serial_addsub_nbit;

    logic        clk;
    logic        rst;
    logic [2:0]  v_drv;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic        cin_drv;
    logic        sub_drv;
    logic        out_ready_drv;

    logic        ready0, valid0, carry0, ovf0;
    logic [7:0]  sum0;
    logic        ready1, valid1, carry1, ovf1;
    logic [7:0]  sum1;
    logic        ready2, valid2, carry2, ovf2;
    logic [15:0] sum2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    serial_addsub_nbit #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_drv[0]), .o_ready(ready0),
        .i_a(a_drv[7:0]), .i_b(b_drv[7:0]), .i_cin(cin_drv), .i_sub(sub_drv),
        .o_valid(valid0), .i_out_ready(out_ready_drv), .o_sum(sum0),
        .o_carry(carry0), .o_overflow(ovf0)
    );

    serial_addsub_nbit #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_drv[1]), .o_ready(ready1),
        .i_a(a_drv[7:0]), .i_b(b_drv[7:0]), .i_cin(cin_drv), .i_sub(sub_drv),
        .o_valid(valid1), .i_out_ready(out_ready_drv), .o_sum(sum1),
        .o_carry(carry1), .o_overflow(ovf1)
    );

    serial_addsub_nbit #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_drv[2]), .o_ready(ready2),
        .i_a(a_drv), .i_b(b_drv), .i_cin(cin_drv), .i_sub(sub_drv),
        .o_valid(valid2), .i_out_ready(out_ready_drv), .o_sum(sum2),
        .o_carry(carry2), .o_overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output view of whichever instance is under test.
    int          sel;
    logic        sel_ready, sel_valid, sel_carry, sel_ovf;
    logic [15:0] sel_sum;

    always_comb begin
        sel_ready = ready0;
        sel_valid = valid0;
        sel_carry = carry0;
        sel_ovf   = ovf0;
        sel_sum   = {8'h00, sum0};
        case (sel)
            1: begin
                sel_ready = ready1; sel_valid = valid1; sel_carry = carry1;
                sel_ovf = ovf1; sel_sum = {8'h00, sum1};
            end
            2: begin
                sel_ready = ready2; sel_valid = valid2; sel_carry = carry2;
                sel_ovf = ovf2; sel_sum = sum2;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic int steps_of(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 1);
    endfunction

    // Reference arithmetic: widen, add, pick the carry bit, derive overflow
    // from operand/result signs.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] bb;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {16'h0, cin ^ sub};
        e.sum   = full[15:0] & mask;
        e.carry = full[w];
        e.ovf   = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub);
        sel = d;
        @(negedge clk);
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub;
        v_drv = 3'b000;
        v_drv[d] = 1'b1;
        sb_q.push_back(model(width_of(d), a, b, cin, sub));
        #1;
        check("ready_before_accept", {31'b0, sel_ready}, 32'd1);
        @(posedge clk);
        #1;
        v_drv = 3'b000;
        check("ready_after_accept", {31'b0, sel_ready}, 32'd0);
    endtask

    // Counts edges from the accept edge to o_valid, then compares against the
    // oldest queued expectation.
    task automatic wait_result(input string tag);
        int   n = 0;
        logic busy_ready = 1'b0;
        exp_t e;
        while (!sel_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!sel_valid && sel_ready) busy_ready = 1'b1;
        end
        check({tag, "_latency"}, n, steps_of(sel));
        check({tag, "_ready_in_calc"}, {31'b0, busy_ready}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sum"}, {16'b0, sel_sum}, {16'b0, e.sum});
            check({tag, "_carry"}, {31'b0, sel_carry}, {31'b0, e.carry});
            check({tag, "_ovf"}, {31'b0, sel_ovf}, {31'b0, e.ovf});
        end
        $display("op %s dut=%0d latency=%0d sum=%h carry=%b ovf=%b",
                 tag, sel, n, sel_sum, sel_carry, sel_ovf);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready_drv = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, {31'b0, sel_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, sel_ready}, 32'd1);
        @(negedge clk);
        out_ready_drv = 1'b0;
    endtask

    task automatic run_op(input string tag, input int d, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic sub);
        start_op(d, a, b, cin, sub);
        wait_result(tag);
        release_result(tag);
    endtask

    initial begin
        logic [15:0] snap_sum;
        logic        snap_carry, snap_ovf, seen_valid;

        sel = 0;
        rst = 1'b1;
        v_drv = 3'b000;
        a_drv = '0; b_drv = '0; cin_drv = 1'b0; sub_drv = 1'b0;
        out_ready_drv = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, valid0}, 32'd0);
        check("rst_ready", {31'b0, ready0}, 32'd0);
        check("rst_sum", {24'b0, sum0}, 32'd0);
        check("rst_carry", {31'b0, carry0}, 32'd0);
        check("rst_ovf", {31'b0, ovf0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, ready0}, 32'd1);

        // WIDTH=8, BPC=1
        run_op("add_0f_01", 0, 16'h0F, 16'h01, 1'b0, 1'b0);
        run_op("add_7f_01", 0, 16'h7F, 16'h01, 1'b0, 1'b0);
        run_op("add_ff_01", 0, 16'hFF, 16'h01, 1'b0, 1'b0);
        run_op("sub_05_07", 0, 16'h05, 16'h07, 1'b0, 1'b1);
        run_op("sub_80_01", 0, 16'h80, 16'h01, 1'b0, 1'b1);
        run_op("sub_10_01_b", 0, 16'h10, 16'h01, 1'b1, 1'b1);

        // Backpressure: hold the result for 5 cycles while a new request waits.
        start_op(0, 16'h3C, 16'h5A, 1'b1, 1'b0);
        wait_result("bp");
        snap_sum = sel_sum; snap_carry = sel_carry; snap_ovf = sel_ovf;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_drv = 16'h11; b_drv = 16'h22; v_drv[0] = 1'b1;
            @(posedge clk);
            #1;
            check("bp_valid", {31'b0, valid0}, 32'd1);
            check("bp_sum", {16'b0, sel_sum}, {16'b0, snap_sum});
            check("bp_carry", {31'b0, carry0}, {31'b0, snap_carry});
            check("bp_ovf", {31'b0, ovf0}, {31'b0, snap_ovf});
            check("bp_ready", {31'b0, ready0}, 32'd0);
        end
        @(negedge clk);
        v_drv = 3'b000;
        release_result("bp");

        // Reset during CALC, at step 3.
        start_op(0, 16'h33, 16'h44, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'b0, valid0}, 32'd0);
        check("midrst_ready", {31'b0, ready0}, 32'd0);
        check("midrst_sum", {24'b0, sum0}, 32'd0);
        check("midrst_carry", {31'b0, carry0}, 32'd0);
        check("midrst_ovf", {31'b0, ovf0}, 32'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valid0) seen_valid = 1'b1;
        end
        check("midrst_no_valid", {31'b0, seen_valid}, 32'd0);
        run_op("add_01_01", 0, 16'h01, 16'h01, 1'b0, 1'b0);

        // WIDTH=8, BPC=4 and WIDTH=16, BPC=16
        run_op("bpc4_ab_55", 1, 16'hAB, 16'h55, 1'b1, 1'b0);
        run_op("bpc4_sub_80_01", 1, 16'h80, 16'h01, 1'b0, 1'b1);
        run_op("w16_ffff_0001", 2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("w16_sub_8000_1", 2, 16'h8000, 16'h0001, 1'b0, 1'b1);

        check("queue_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_nbit.md
Name: serial_addsub_nbit

Overview:
- Parametrised, multi-cycle adder/subtractor for WIDTH-bit operands, with ripple logic of BITS_PER_CYCLE full-adder slices.
- Processes BITS_PER_CYCLE bits per clock, LSB first, and carries between steps in a register. This trades latency for area.
- Valid/ready handshakes on input and output make it a drop-in arithmetic unit for small datapaths and serial-ALU builds.

Parameters:
- WIDTH, 8, operand and sum width; minimum 2.
- BITS_PER_CYCLE, 1, bits resolved per clock; must divide WIDTH exactly.
  - Elaboration fails if it does not.
  - STEPS = WIDTH/BITS_PER_CYCLE.

Ports:
- i_clk, input, 1, clock; all logic on the rising edge.
- i_rst, input, 1, synchronous, active-high reset.
- i_valid, input, 1, operand request valid.
- o_ready, output, 1, block can accept operands.
- i_a, input, WIDTH, operand A.
- i_b, input, WIDTH, operand B.
- i_cin, input, 1, carry-in when adding; borrow-in when subtracting.
- i_sub, input, 1, 0 = A+B+cin; 1 = A-B-cin.
- o_valid, output, 1, result valid.
- i_out_ready, input, 1, downstream accepts result.
- o_sum, output, WIDTH, result.
- o_carry, output, 1, carry-out of the MSB; for subtract, 1 = no borrow.
- o_overflow, output, 1, two's-complement signed overflow.

Behaviour:
- Reset: synchronous, on any edge with i_rst=1.
  - State goes to IDLE; step counter = 0; carry register = 0.
  - o_valid = 0; o_sum = 0; o_carry = 0; o_overflow = 0.
  - o_ready = 0 while i_rst is high.
  - Reset overrides every other event. A reset during CALC or DONE discards the operation and no o_valid is produced.
- States: IDLE, CALC, DONE. o_ready = 1 only in IDLE (and i_rst low).
- IDLE: on i_valid & o_ready at an edge:
  - Capture A.
  - Capture B' = i_sub ? ~i_b : i_b.
  - Set the carry register to i_cin ^ i_sub.
  - Clear the counter and go to CALC.
  - i_valid without o_ready is ignored; the source must hold its request.
- CALC, each cycle:
  - Add the low BITS_PER_CYCLE bits of A and B' plus the carry register through a ripple of full-adder slices.
  - Shift A and B' right by BITS_PER_CYCLE.
  - Shift the partial sum into the top of the result register (LSB-first assembly).
  - Update the carry register and increment the counter.
- On the step where counter = STEPS-1:
  - Also record the carry into the MSB slice and the carry out of the MSB.
  - Go to DONE at that edge.
- Latency: accept at edge k gives o_valid=1 after edge k+STEPS.
- DONE:
  - o_valid = 1.
  - o_sum = final result.
  - o_carry = final carry.
  - o_overflow = (carry into MSB) XOR (carry out of MSB).
- Output handshake: outputs stay stable while o_valid=1 and i_out_ready=0.
  - On o_valid & i_out_ready at an edge: o_valid goes to 0 and the state goes to IDLE.
  - o_sum, o_carry and o_overflow keep their last values; they are don't-care when o_valid=0.
- Throughput: one operation per STEPS+2 cycles minimum, because accepts are not overlapped with DONE.
- Operand inputs are sampled only at the accept edge. Changes to them during CALC or DONE have no effect.
- Arithmetic: all sums are modulo 2^WIDTH.
  - The subtract carry convention is a raw carry, not a borrow: A-B with A>=B unsigned gives o_carry=1.
- BITS_PER_CYCLE = WIDTH degenerates to STEPS=1: a single CALC cycle, latency 1.

Test Plan:
- Add, WIDTH=8, BPC=1, A=0x0F, B=0x01, cin=0, sub=0.
  - Expect o_sum=0x10, carry=0, ovf=0.
  - o_valid rises exactly 8 edges after the accept; o_ready=0 throughout CALC.
- Add boundaries, WIDTH=8, BPC=1:
  - 0x7F+0x01 -> 0x80, carry=0, ovf=1.
  - 0xFF+0x01 -> 0x00, carry=1, ovf=0.
- Subtract, WIDTH=8, BPC=1:
  - 0x05-0x07, cin=0 -> 0xFE, carry=0, ovf=0.
  - 0x80-0x01 -> 0x7F, carry=1, ovf=1.
  - 0x10-0x01 with cin=1 (borrow) -> 0x0E, carry=1.
- Backpressure: hold i_out_ready=0 for 5 cycles in DONE.
  - o_valid, o_sum, o_carry and o_overflow stay constant; o_ready stays 0.
  - New i_valid is ignored.
  - Raise i_out_ready: o_valid drops next edge and o_ready=1 the cycle after.
- Reset mid-operation: assert i_rst for 1 cycle at step 3 of CALC.
  - All outputs clear; no o_valid appears.
  - A following request 0x01+0x01 completes normally with 0x02.
- WIDTH=8, BPC=4: A=0xAB, B=0x55, cin=1, sub=0.
  - Expect o_sum=0x01, carry=1, ovf=0, with o_valid exactly 2 edges after the accept.
  - Repeat with WIDTH=16, BPC=16: latency 1 edge; 0xFFFF+0x0001 -> 0x0000, carry=1.
